rx_frame_parser: RTL and testbench

- Sits between the GXB RX transceiver output and the RX buffer controller, in the rx_std_clkout domain.
- Qualifies each 16-bit word with syncstatus and datak, delimits frames using K-character words, and validates length and checksum.
- Streams payload words downstream with sof/eof/err markers and keeps saturating good/bad frame counters.
- Has no backpressure: the downstream side must accept one word per cycle at line rate.

---
 rtl/dm_rx_pkg.sv | 23 ++
 rtl/rx_frame_parser_if.sv | 11 +
 rtl/rx_frame_stats.sv | 31 +++
 rtl/rx_frame_parser.sv | 175 +++++++++++++++++
 tb/tb_rx_frame_parser.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_rx_pkg.sv
// Shared K-character codes, parser state encoding and saturating-increment helper
// for the RX frame parser slice.
package dm_rx_pkg;

  localparam logic [7:0] K_IDLE = 8'hBC;
  localparam logic [7:0] K_SOF  = 8'hFB;
  localparam logic [7:0] K_EOF  = 8'hFD;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    LEN  = 2'd1,
    PAY  = 2'd2,
    EOFW = 2'd3
  } state_t;

  // Increment that sticks at the all-ones value of a width-bit counter (width 1..32).
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_v;
    max_v = 32'hFFFF_FFFF >> (32 - width);
    return (val == max_v) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/rx_frame_parser_if.sv
// Downstream payload stream from the RX frame parser; no backpressure.
interface rx_frame_parser_if;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_sof;
  logic        out_eof;
  logic        out_err;

  modport master (output out_data, out_valid, out_sof, out_eof, out_err);
  modport slave  (input  out_data, out_valid, out_sof, out_eof, out_err);
endinterface

// File: rtl/rx_frame_stats.sv
// Saturating good/bad frame counters for the RX frame parser.
module rx_frame_stats
  import dm_rx_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_ok,
  input  logic             inc_err,
  output logic [CNT_W-1:0] frames_ok,
  output logic [CNT_W-1:0] frames_err
);

  logic [CNT_W-1:0] ok_q;
  logic [CNT_W-1:0] err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_q  <= '0;
      err_q <= '0;
    end else begin
      if (inc_ok)  ok_q  <= CNT_W'(sat_inc(32'(ok_q), CNT_W));
      if (inc_err) err_q <= CNT_W'(sat_inc(32'(err_q), CNT_W));
    end
  end

  assign frames_ok  = ok_q;
  assign frames_err = err_q;

endmodule

// File: rtl/rx_frame_parser.sv
// Delimits K-character framed payloads from the transceiver, checks length and XOR checksum.
// Optional macro RX_SEQ_CHECK_EN adds SOF sequence-number continuity checking.
module rx_frame_parser
  import dm_rx_pkg::*;
#(
  parameter int MAX_LEN = 256,
  parameter int CNT_W   = 16
) (
  input  logic              rx_std_clkout,
  input  logic              rst_n,
  input  logic [15:0]       rx_parallel_data,
  input  logic [1:0]        rx_datak,
  input  logic [1:0]        rx_syncstatus,
  rx_frame_parser_if.master out_if,
  output logic [CNT_W-1:0]  frames_ok,
  output logic [CNT_W-1:0]  frames_err,
  output logic              in_frame
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  state_t           state;
  logic [LEN_W-1:0] remain;
  logic [7:0]       csum;
  logic             first_pend;
  logic             vld_p0;
  logic             sof_p0;
  logic [15:0]      data_p0;

  logic [7:0] byte0, byte1;
  logic       locked, data_word, sof_word, eof_word, len_ok;
  logic       sof_accept, pay_accept, frame_bad;
  logic       inc_ok, inc_err;

  assign byte0      = rx_parallel_data[7:0];
  assign byte1      = rx_parallel_data[15:8];
  assign locked     = (rx_syncstatus == 2'b11);
  assign data_word  = (rx_datak == 2'b00);
  assign sof_word   = (rx_datak == 2'b01) && (byte0 == K_SOF);
  assign eof_word   = (rx_datak == 2'b01) && (byte0 == K_EOF);
  assign len_ok     = data_word && (rx_parallel_data != 16'd0) &&
                      (rx_parallel_data <= 16'(MAX_LEN));
  assign sof_accept = (state == HUNT) && locked && sof_word;
  assign pay_accept = (state == PAY) && locked && data_word;

`ifdef RX_SEQ_CHECK_EN
  logic [7:0] seq_exp;
  logic       seq_seen;
  logic       seq_bad;

  // The first SOF after reset only seeds the expectation.
  always_ff @(posedge rx_std_clkout or negedge rst_n) begin
    if (!rst_n) begin
      seq_exp  <= '0;
      seq_seen <= 1'b0;
      seq_bad  <= 1'b0;
    end else if (sof_accept) begin
      seq_bad  <= seq_seen && (byte1 != seq_exp);
      seq_exp  <= byte1 + 8'd1;
      seq_seen <= 1'b1;
    end
  end
`else
  logic seq_bad;
  assign seq_bad = 1'b0;
`endif

  assign frame_bad = !(locked && eof_word) || (byte1 != csum) || seq_bad;

  // Counter strobes are combinational so the counters move on the same edge as out_eof.
  assign inc_ok  = (state == EOFW) && !frame_bad;
  assign inc_err = ((state == LEN) && !(locked && len_ok)) ||
                   ((state == PAY) && !(locked && data_word)) ||
                   ((state == EOFW) && frame_bad);

  // Stage p0: one-word hold register, data path without reset
  always_ff @(posedge rx_std_clkout) begin
    if (pay_accept) data_p0 <= rx_parallel_data;
  end

  always_ff @(posedge rx_std_clkout or negedge rst_n) begin
    if (!rst_n) begin
      state            <= HUNT;
      remain           <= '0;
      csum             <= '0;
      first_pend       <= 1'b0;
      vld_p0           <= 1'b0;
      sof_p0           <= 1'b0;
      in_frame         <= 1'b0;
      out_if.out_data  <= '0;
      out_if.out_valid <= 1'b0;
      out_if.out_sof   <= 1'b0;
      out_if.out_eof   <= 1'b0;
      out_if.out_err   <= 1'b0;
    end else begin
      out_if.out_valid <= 1'b0;
      out_if.out_sof   <= 1'b0;
      out_if.out_eof   <= 1'b0;
      out_if.out_err   <= 1'b0;
      case (state)
        HUNT: begin
          if (sof_accept) begin
            state      <= LEN;
            in_frame   <= 1'b1;
            csum       <= '0;
            first_pend <= 1'b1;
            vld_p0     <= 1'b0;
          end
        end
        LEN: begin
          if (locked && len_ok) begin
            remain <= LEN_W'(rx_parallel_data);
            state  <= PAY;
          end else begin
            state    <= HUNT;
            in_frame <= 1'b0;
          end
        end
        PAY: begin
          if (pay_accept) begin
            if (vld_p0) begin
              out_if.out_valid <= 1'b1;
              out_if.out_data  <= data_p0;
              out_if.out_sof   <= sof_p0;
            end
            vld_p0     <= 1'b1;
            sof_p0     <= first_pend;
            first_pend <= 1'b0;
            csum       <= csum ^ byte0 ^ byte1;
            remain     <= remain - LEN_W'(1);
            if (remain == LEN_W'(1)) state <= EOFW;
          end else begin
            // Abort: flush whatever is held as a bad end of frame.
            if (vld_p0) begin
              out_if.out_valid <= 1'b1;
              out_if.out_data  <= data_p0;
              out_if.out_sof   <= sof_p0;
              out_if.out_eof   <= 1'b1;
              out_if.out_err   <= 1'b1;
            end
            vld_p0   <= 1'b0;
            state    <= HUNT;
            in_frame <= 1'b0;
          end
        end
        EOFW: begin
          out_if.out_valid <= 1'b1;
          out_if.out_data  <= data_p0;
          out_if.out_sof   <= sof_p0;
          out_if.out_eof   <= 1'b1;
          out_if.out_err   <= frame_bad;
          vld_p0           <= 1'b0;
          state            <= HUNT;
          in_frame         <= 1'b0;
        end
        default: begin
          state    <= HUNT;
          in_frame <= 1'b0;
        end
      endcase
    end
  end

  rx_frame_stats #(
    .CNT_W (CNT_W)
  ) u_stats (
    .clk        (rx_std_clkout),
    .rst_n      (rst_n),
    .inc_ok     (inc_ok),
    .inc_err    (inc_err),
    .frames_ok  (frames_ok),
    .frames_err (frames_err)
  );

endmodule

// File: tb/tb_rx_frame_parser.sv
// Directed bench for rx_frame_parser: framing, checksum, length limits, aborts, counters.
module tb_rx_frame_parser;
  import dm_rx_pkg::*;

  localparam int MAX_LEN = 256;
  localparam int CNT_W   = 16;

  typedef struct packed {
    logic [15:0] d;
    logic        sof;
    logic        eof;
    logic        err;
  } obs_t;

  logic             clk;
  logic             rst_n;
  logic [15:0]      rx_parallel_data;
  logic [1:0]       rx_datak;
  logic [1:0]       rx_syncstatus;
  logic [CNT_W-1:0] frames_ok;
  logic [CNT_W-1:0] frames_err;
  logic             in_frame;

  rx_frame_parser_if bus ();

  rx_frame_parser #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .rx_std_clkout    (clk),
    .rst_n            (rst_n),
    .rx_parallel_data (rx_parallel_data),
    .rx_datak         (rx_datak),
    .rx_syncstatus    (rx_syncstatus),
    .out_if           (bus),
    .frames_ok        (frames_ok),
    .frames_err       (frames_err),
    .in_frame         (in_frame)
  );

  int n_checks = 0;
  int n_pass   = 0;
  obs_t obs_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && bus.out_valid)
      obs_q.push_back({bus.out_data, bus.out_sof, bus.out_eof, bus.out_err});
  end

  function automatic obs_t get_obs(input int i);
    obs_t o;
    o = '0;
    if (i < obs_q.size()) o = obs_q[i];
    return o;
  endfunction

  task automatic send(input logic [1:0] k, input logic [15:0] d);
    rx_datak         = k;
    rx_parallel_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(2'b01, {8'h00, K_IDLE});
  endtask

  task automatic sof(input logic [7:0] seq);
    send(2'b01, {seq, K_SOF});
  endtask

  task automatic eofw(input logic [7:0] cs);
    send(2'b01, {cs, K_EOF});
  endtask

  task automatic dat(input logic [15:0] d);
    send(2'b00, d);
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    rx_syncstatus    = 2'b11;
    rx_datak         = 2'b01;
    rx_parallel_data = {8'h00, K_IDLE};
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    obs_q.delete();
  endtask

  // LEN=1 frame, payload 0xBEEF, checksum 0xBE^0xEF = 0x51.
  task automatic short_frame(input logic [7:0] seq);
    sof(seq);
    dat(16'd1);
    dat(16'hBEEF);
    eofw(8'h51);
    idle(2);
  endtask

  task automatic test_reset();
    rst_n            = 1'b0;
    rx_syncstatus    = 2'b11;
    rx_datak         = 2'b01;
    rx_parallel_data = {8'h00, K_IDLE};
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b exp 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_data !== 16'h0) $display("FAIL reset_data: got %h exp 0000", bus.out_data); else n_pass++;
    n_checks++; if (frames_ok !== '0) $display("FAIL reset_ok: got %0d exp 0", frames_ok); else n_pass++;
    n_checks++; if (frames_err !== '0) $display("FAIL reset_err: got %0d exp 0", frames_err); else n_pass++;
    n_checks++; if (in_frame !== 1'b0) $display("FAIL reset_in_frame: got %b exp 0", in_frame); else n_pass++;
  endtask

  // Payload 0x1234,0xABCD,0x0F0F: 0x12^0x34^0xAB^0xCD^0x0F^0x0F = 0x40.
  task automatic test_good_frame();
    do_reset();
    idle(3);
    sof(8'h05);
    dat(16'd3);
    dat(16'h1234);
    dat(16'hABCD);
    dat(16'h0F0F);
    n_checks++; if (in_frame !== 1'b1) $display("FAIL good_in_frame: got %b exp 1", in_frame); else n_pass++;
    eofw(8'h40);
    idle(2);
    n_checks++; if (obs_q.size() !== 3) $display("FAIL good_count: got %0d exp 3", obs_q.size()); else n_pass++;
    n_checks++; if (get_obs(0) !== {16'h1234, 1'b1, 1'b0, 1'b0}) $display("FAIL good_w0: got %h exp %h", get_obs(0), {16'h1234, 3'b100}); else n_pass++;
    n_checks++; if (get_obs(1) !== {16'hABCD, 1'b0, 1'b0, 1'b0}) $display("FAIL good_w1: got %h exp %h", get_obs(1), {16'hABCD, 3'b000}); else n_pass++;
    n_checks++; if (get_obs(2) !== {16'h0F0F, 1'b0, 1'b1, 1'b0}) $display("FAIL good_w2: got %h exp %h", get_obs(2), {16'h0F0F, 3'b010}); else n_pass++;
    n_checks++; if (frames_ok !== 16'd1) $display("FAIL good_ok: got %0d exp 1", frames_ok); else n_pass++;
    n_checks++; if (frames_err !== 16'd0) $display("FAIL good_err: got %0d exp 0", frames_err); else n_pass++;
    n_checks++; if (in_frame !== 1'b0) $display("FAIL good_in_frame_end: got %b exp 0", in_frame); else n_pass++;
  endtask

  task automatic test_bad_csum();
    do_reset();
    sof(8'h05);
    dat(16'd3);
    dat(16'h1234);
    dat(16'hABCD);
    dat(16'h0F0F);
    eofw(8'h00);
    idle(2);
    n_checks++; if (obs_q.size() !== 3) $display("FAIL csum_count: got %0d exp 3", obs_q.size()); else n_pass++;
    n_checks++; if (get_obs(2) !== {16'h0F0F, 1'b0, 1'b1, 1'b1}) $display("FAIL csum_last: got %h exp %h", get_obs(2), {16'h0F0F, 3'b011}); else n_pass++;
    n_checks++; if (frames_err !== 16'd1) $display("FAIL csum_err_cnt: got %0d exp 1", frames_err); else n_pass++;
    n_checks++; if (frames_ok !== 16'd0) $display("FAIL csum_ok_cnt: got %0d exp 0", frames_ok); else n_pass++;
  endtask

  task automatic test_len_reject();
    do_reset();
    sof(8'h01);
    dat(16'd0);
    idle(2);
    sof(8'h02);
    dat(16'(MAX_LEN + 1));
    idle(2);
    n_checks++; if (obs_q.size() !== 0) $display("FAIL len_no_output: got %0d exp 0", obs_q.size()); else n_pass++;
    n_checks++; if (frames_err !== 16'd2) $display("FAIL len_err_cnt: got %0d exp 2", frames_err); else n_pass++;
    n_checks++; if (in_frame !== 1'b0) $display("FAIL len_in_frame: got %b exp 0", in_frame); else n_pass++;
    sof(8'h03);
    dat(16'd3);
    dat(16'h1234);
    dat(16'hABCD);
    dat(16'h0F0F);
    eofw(8'h40);
    idle(2);
    n_checks++; if (obs_q.size() !== 3) $display("FAIL len_recover_count: got %0d exp 3", obs_q.size()); else n_pass++;
    n_checks++; if (frames_ok !== 16'd1) $display("FAIL len_recover_ok: got %0d exp 1", frames_ok); else n_pass++;
  endtask

  task automatic test_sync_loss();
    do_reset();
    sof(8'h09);
    dat(16'd4);
    dat(16'h1111);
    dat(16'h2222);
    n_checks++; if ({bus.out_valid, bus.out_data, bus.out_sof, bus.out_eof, bus.out_err} !== {1'b1, 16'h1111, 3'b100})
      $display("FAIL sync_w1: got %h exp %h", {bus.out_valid, bus.out_data, bus.out_sof, bus.out_eof, bus.out_err}, {1'b1, 16'h1111, 3'b100}); else n_pass++;
    rx_syncstatus = 2'b01;
    dat(16'h3333);
    n_checks++; if ({bus.out_valid, bus.out_data, bus.out_sof, bus.out_eof, bus.out_err} !== {1'b1, 16'h2222, 3'b011})
      $display("FAIL sync_w2: got %h exp %h", {bus.out_valid, bus.out_data, bus.out_sof, bus.out_eof, bus.out_err}, {1'b1, 16'h2222, 3'b011}); else n_pass++;
    n_checks++; if (in_frame !== 1'b0) $display("FAIL sync_in_frame: got %b exp 0", in_frame); else n_pass++;
    n_checks++; if (frames_err !== 16'd1) $display("FAIL sync_err_cnt: got %0d exp 1", frames_err); else n_pass++;
    rx_syncstatus = 2'b11;
    idle(2);
    n_checks++; if (obs_q.size() !== 2) $display("FAIL sync_count: got %0d exp 2", obs_q.size()); else n_pass++;
  endtask

  // A SOF inside the payload aborts; it is not itself accepted, so the words after it are ignored.
  task automatic test_k_abort();
    do_reset();
    sof(8'h00);
    dat(16'd2);
    dat(16'hAAAA);
    sof(8'h01);
    dat(16'd1);
    dat(16'h5555);
    eofw(8'h00);
    idle(2);
    n_checks++; if (obs_q.size() !== 1) $display("FAIL kab_count: got %0d exp 1", obs_q.size()); else n_pass++;
    n_checks++; if (get_obs(0) !== {16'hAAAA, 1'b1, 1'b1, 1'b1}) $display("FAIL kab_word: got %h exp %h", get_obs(0), {16'hAAAA, 3'b111}); else n_pass++;
    n_checks++; if (frames_err !== 16'd1) $display("FAIL kab_err_cnt: got %0d exp 1", frames_err); else n_pass++;
    n_checks++; if (frames_ok !== 16'd0) $display("FAIL kab_ok_cnt: got %0d exp 0", frames_ok); else n_pass++;
  endtask

  task automatic test_len1();
    do_reset();
    short_frame(8'h20);
    n_checks++; if (obs_q.size() !== 1) $display("FAIL len1_count: got %0d exp 1", obs_q.size()); else n_pass++;
    n_checks++; if (get_obs(0) !== {16'hBEEF, 1'b1, 1'b1, 1'b0}) $display("FAIL len1_word: got %h exp %h", get_obs(0), {16'hBEEF, 3'b110}); else n_pass++;
    n_checks++; if (frames_ok !== 16'd1) $display("FAIL len1_ok: got %0d exp 1", frames_ok); else n_pass++;
  endtask

  // EOF of frame A is followed immediately by SOF of frame B.
  task automatic test_back_to_back();
    do_reset();
    sof(8'h30);
    dat(16'd2);
    dat(16'h0102);
    dat(16'h0304);
    eofw(8'h04);
    sof(8'h31);
    dat(16'd1);
    dat(16'h00FF);
    eofw(8'hFF);
    idle(2);
    n_checks++; if (obs_q.size() !== 3) $display("FAIL b2b_count: got %0d exp 3", obs_q.size()); else n_pass++;
    n_checks++; if (get_obs(1) !== {16'h0304, 1'b0, 1'b1, 1'b0}) $display("FAIL b2b_a_last: got %h exp %h", get_obs(1), {16'h0304, 3'b010}); else n_pass++;
    n_checks++; if (get_obs(2) !== {16'h00FF, 1'b1, 1'b1, 1'b0}) $display("FAIL b2b_b: got %h exp %h", get_obs(2), {16'h00FF, 3'b110}); else n_pass++;
    n_checks++; if (frames_ok !== 16'd2) $display("FAIL b2b_ok: got %0d exp 2", frames_ok); else n_pass++;
  endtask

  task automatic test_saturation();
    do_reset();
    @(negedge clk);
    force dut.u_stats.ok_q = 16'hFFFE;
    @(negedge clk);
    release dut.u_stats.ok_q;
    @(posedge clk);
    #1;
    n_checks++; if (frames_ok !== 16'hFFFE) $display("FAIL sat_preload: got %h exp fffe", frames_ok); else n_pass++;
    short_frame(8'h40);
    n_checks++; if (frames_ok !== 16'hFFFF) $display("FAIL sat_first: got %h exp ffff", frames_ok); else n_pass++;
    short_frame(8'h41);
    short_frame(8'h42);
    n_checks++; if (frames_ok !== 16'hFFFF) $display("FAIL sat_hold: got %h exp ffff", frames_ok); else n_pass++;
    n_checks++; if (frames_err !== 16'd0) $display("FAIL sat_err: got %0d exp 0", frames_err); else n_pass++;
  endtask

`ifdef RX_SEQ_CHECK_EN
  task automatic test_seq_check();
    do_reset();
    short_frame(8'd7);
    short_frame(8'd8);
    short_frame(8'd10);
    n_checks++; if (get_obs(0).err !== 1'b0) $display("FAIL seq_f7: got %b exp 0", get_obs(0).err); else n_pass++;
    n_checks++; if (get_obs(1).err !== 1'b0) $display("FAIL seq_f8: got %b exp 0", get_obs(1).err); else n_pass++;
    n_checks++; if (get_obs(2).err !== 1'b1) $display("FAIL seq_f10: got %b exp 1", get_obs(2).err); else n_pass++;
    n_checks++; if (frames_err !== 16'd1) $display("FAIL seq_err_cnt: got %0d exp 1", frames_err); else n_pass++;
  endtask
`endif

  initial begin
    rst_n            = 1'b0;
    rx_syncstatus    = 2'b11;
    rx_datak         = 2'b01;
    rx_parallel_data = {8'h00, K_IDLE};
    #2;
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_len_reject();
    test_sync_loss();
    test_k_abort();
    test_len1();
    test_back_to_back();
    test_saturation();
`ifdef RX_SEQ_CHECK_EN
    test_seq_check();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
